// File: rtl/regfile_ctrl_pkg.sv
// Shared types and constants for the register-file arbiter slice.
package regfile_ctrl_pkg;

  // Controller state: normal arbitration, or sweeping the file to zero after reset.
  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_CLEAR = 1'b1
  } rf_state_e;

  // Requester identifiers, also the grant-pointer encoding.
  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  // Access opcodes as carried on the reqN_we inputs.
  localparam logic OP_RD = 1'b0;
  localparam logic OP_WR = 1'b1;

endpackage

// File: rtl/register_file.sv
// Register file: one synchronous write port, one combinational read port.
module register_file #(
  parameter int B = 32,
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         wr_en,
  input  logic [W-1:0] w_addr,
  input  logic [B-1:0] w_data,
  input  logic [W-1:0] r_addr,
  output logic [B-1:0] r_data
);

  logic [B-1:0] mem [2**W];

  // Write commits at the clock edge.
  always_ff @(posedge clk) begin
    if (wr_en) mem[w_addr] <= w_data;
  end

  assign r_data = mem[r_addr];

endmodule

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter. The grant is combinational from req and the
// priority pointer; the pointer flips to the other requester on every
// advanced grant so a continuous tie alternates 0,1,0,1.
module rr_arbiter2
  import regfile_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  logic ptr;

  // Grant: a lone request wins; a tie goes to the pointer.
  always_comb begin
    gnt = req;
    if (req == 2'b11) gnt = (ptr == REQ1) ? 2'b10 : 2'b01;
  end

  // Pointer moves to whichever requester did not just win.
  always_ff @(posedge clk) begin
    if (rst)          ptr <= REQ0;
    else if (advance) ptr <= gnt[0] ? REQ1 : REQ0;
  end

endmodule

// File: rtl/regfile_arbiter.sv
// Round-robin front end for a 1W/1R register file shared by two requesters.
// Pipeline: accept in C, drive rf_* from registers in C+1, respond in C+2.
// Handshake: a request transfers in a cycle where reqN_valid and reqN_ready
// are both high; the requester holds valid and payload until ready. ready
// depends only on both valids, the priority pointer, the FSM state and rst.
// Optional build macro RF_CLEAR_ON_RESET_EN: after reset, sweep zeros into
// every address (init_busy high, no grants) before normal arbitration.
module regfile_arbiter
  import regfile_ctrl_pkg::*;
#(
  parameter int B = 32,
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  input  logic         req0_we,
  input  logic [W-1:0] req0_addr,
  input  logic [B-1:0] req0_wdata,
  output logic         req0_ready,
  input  logic         req1_valid,
  input  logic         req1_we,
  input  logic [W-1:0] req1_addr,
  input  logic [B-1:0] req1_wdata,
  output logic         req1_ready,
  output logic         rsp0_valid,
  output logic [B-1:0] rsp0_rdata,
  output logic         rsp1_valid,
  output logic [B-1:0] rsp1_rdata,
  output logic         rf_wr_en,
  output logic [W-1:0] rf_w_addr,
  output logic [B-1:0] rf_w_data,
  output logic [W-1:0] rf_r_addr,
  input  logic [B-1:0] rf_r_data,
  output logic         init_busy,
  output rf_state_e    dbg_state
);

`ifdef RF_CLEAR_ON_RESET_EN
  localparam rf_state_e RESET_STATE = ST_CLEAR;
`else
  localparam rf_state_e RESET_STATE = ST_RUN;
`endif

  rf_state_e state, state_next;

  logic [1:0]   gnt;
  logic [1:0]   ready;
  logic         run;
  logic         accept;
  logic         acc_id;
  logic         acc_we;
  logic [W-1:0] acc_addr;
  logic [B-1:0] acc_wdata;

  // Issue stage (drives the register file in C+1).
  logic         iss_valid;
  logic         iss_id;
  logic         iss_we;
  logic         wr_en_q;
  logic [W-1:0] w_addr_q;
  logic [B-1:0] w_data_q;
  logic [W-1:0] r_addr_q;

`ifdef RF_CLEAR_ON_RESET_EN
  logic [W-1:0] clr_cnt;
  logic         clear_active;
  assign clear_active = (state == ST_CLEAR) && !rst;
`endif

  rr_arbiter2 u_rr (
    .clk     (clk),
    .rst     (rst),
    .req     ({req1_valid, req0_valid}),
    .advance (accept),
    .gnt     (gnt)
  );

  // Grants are only offered in RUN and never while reset is asserted.
  assign run        = (state == ST_RUN) && !rst;
  assign ready      = gnt & {2{run}};
  assign req0_ready = ready[0];
  assign req1_ready = ready[1];
  assign accept     = |ready;
  assign acc_id     = ready[1] ? REQ1 : REQ0;

  // Select the winning requester's payload.
  always_comb begin
    acc_we    = req0_we;
    acc_addr  = req0_addr;
    acc_wdata = req0_wdata;
    if (acc_id == REQ1) begin
      acc_we    = req1_we;
      acc_addr  = req1_addr;
      acc_wdata = req1_wdata;
    end
  end

  // FSM state register (plus the clear-sweep address when built in).
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RESET_STATE;
`ifdef RF_CLEAR_ON_RESET_EN
      clr_cnt <= '0;
`endif
    end else begin
      state <= state_next;
`ifdef RF_CLEAR_ON_RESET_EN
      clr_cnt <= (state == ST_CLEAR) ? clr_cnt + 1'b1 : '0;
`endif
    end
  end

  // FSM next state: CLEAR leaves after the last address is written.
  always_comb begin
    state_next = state;
    case (state)
      ST_RUN:   state_next = ST_RUN;
      ST_CLEAR: begin
`ifdef RF_CLEAR_ON_RESET_EN
        if (clr_cnt == {W{1'b1}}) state_next = ST_RUN;
`else
        state_next = ST_RUN;
`endif
      end
      default:  state_next = ST_RUN;
    endcase
  end

  assign dbg_state = state;

  // Issue registers; write and read address/data hold across idle cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      iss_valid <= 1'b0;
      iss_id    <= REQ0;
      iss_we    <= OP_RD;
      wr_en_q   <= 1'b0;
      w_addr_q  <= '0;
      w_data_q  <= '0;
      r_addr_q  <= '0;
    end else begin
      iss_valid <= accept;
      wr_en_q   <= accept && (acc_we == OP_WR);
      if (accept) begin
        iss_id <= acc_id;
        iss_we <= acc_we;
        if (acc_we == OP_WR) begin
          w_addr_q <= acc_addr;
          w_data_q <= acc_wdata;
        end else begin
          r_addr_q <= acc_addr;
        end
      end
`ifdef RF_CLEAR_ON_RESET_EN
      // Track the sweep so the held write address/data match what was driven.
      if (state == ST_CLEAR) begin
        w_addr_q <= clr_cnt;
        w_data_q <= '0;
      end
`endif
    end
  end

`ifdef RF_CLEAR_ON_RESET_EN
  assign rf_wr_en  = clear_active | wr_en_q;
  assign rf_w_addr = clear_active ? clr_cnt : w_addr_q;
  assign rf_w_data = clear_active ? '0 : w_data_q;
  assign init_busy = clear_active;
`else
  assign rf_wr_en  = wr_en_q;
  assign rf_w_addr = w_addr_q;
  assign rf_w_data = w_data_q;
  assign init_busy = 1'b0;
`endif
  assign rf_r_addr = r_addr_q;

  // Response stage: one-cycle pulse to the issuing requester; reads capture
  // the combinational register-file output, writes return zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp0_rdata <= '0;
      rsp1_rdata <= '0;
    end else begin
      rsp0_valid <= iss_valid && (iss_id == REQ0);
      rsp1_valid <= iss_valid && (iss_id == REQ1);
      if (iss_valid && (iss_id == REQ0)) rsp0_rdata <= (iss_we == OP_WR) ? '0 : rf_r_data;
      if (iss_valid && (iss_id == REQ1)) rsp1_rdata <= (iss_we == OP_WR) ? '0 : rf_r_data;
    end
  end

endmodule
